// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller: size codes,
// error codes and the controller FSM encoding.
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_ALIGN = 2'b01,
        ERR_RANGE = 2'b10,
        ERR_SIZE  = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

endpackage

// File: rtl/dm_be_gen.sv
// Byte-enable and alignment decode for a (size, low offset) pair; purely
// combinational so it can be shared with other bus-side blocks.
module dm_be_gen
    import dm_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] off,
    output logic [3:0] be,
    output logic       misaligned
);

    // Lane selection and alignment check per access size
    always_comb begin
        be         = 4'b0000;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << off;
                misaligned = 1'b0;
            end
            SZ_HALF: begin
                be         = off[1] ? 4'b1100 : 4'b0011;
                misaligned = off[0];
            end
            SZ_WORD: begin
                be         = 4'b1111;
                misaligned = |off;
            end
            default: begin
                be         = 4'b0000;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// Load/store controller in front of the data memory: validates a request,
// drives one memory access cycle and reports completion with a done pulse.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter logic [31:0] DM_BASE  = 32'h0000_0000,
    parameter int          DM_WORDS = 1024,
    localparam int         AW       = $clog2(DM_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sign,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [31:0]   rdata,
    output logic [AW-1:0] dm_addr,
    output logic [3:0]    dm_be,
    output logic [31:0]   dm_din,
    output logic          dm_wr,
    output logic          dm_signed,
    input  logic [31:0]   dm_dout
);

    localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

    state_e        state_r, state_s;
    logic [31:0]   offset_s;
    logic [3:0]    be_s;
    logic          mis_s;
    logic          accept_s;
    logic          err_s;
    err_e          code_s;

    logic          busy_r, done_r, err_r;
    err_e          err_code_r;
    logic [31:0]   rdata_r;
    logic [AW-1:0] dm_addr_r;
    logic [3:0]    dm_be_r;
    logic [31:0]   dm_din_r;
    logic          dm_wr_r, dm_signed_r;

    // Addresses below the base wrap to large offsets and so fail the range check
    assign offset_s = addr - DM_BASE;

    dm_be_gen u_be_gen (
        .size       (size),
        .off        (offset_s[1:0]),
        .be         (be_s),
        .misaligned (mis_s)
    );

    // Next-state and request classification
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        err_s    = 1'b0;
        code_s   = ERR_NONE;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    if (size == SZ_BAD) begin
                        err_s  = 1'b1;
                        code_s = ERR_SIZE;
                    end else if (mis_s) begin
                        err_s  = 1'b1;
                        code_s = ERR_ALIGN;
                    end else if (offset_s >= DM_BYTES) begin
                        err_s  = 1'b1;
                        code_s = ERR_RANGE;
                    end else begin
                        accept_s = 1'b1;
                    end
                    state_s = err_s ? ST_DONE : ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_s = ST_DONE;
            ST_DONE:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake outputs; err is only ever raised from IDLE so it pulses with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_s == ST_DONE);
            err_r      <= err_s;
            err_code_r <= code_s;
        end
    end

    // Memory-side registers and MDR capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r     <= 32'h0000_0000;
            dm_addr_r   <= '0;
            dm_be_r     <= 4'b0000;
            dm_din_r    <= 32'h0000_0000;
            dm_wr_r     <= 1'b0;
            dm_signed_r <= 1'b0;
        end else if (accept_s) begin
            dm_addr_r   <= offset_s[AW+1:2];
            dm_be_r     <= be_s;
            dm_din_r    <= wdata;
            dm_wr_r     <= we;
            dm_signed_r <= sign;
        end else if (state_r == ST_ACCESS) begin
            // dm_wr_r still reflects the request direction during ACCESS
            if (!dm_wr_r) begin
                rdata_r <= dm_dout;
            end
            dm_wr_r <= 1'b0;
            dm_be_r <= 4'b0000;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign err_code  = err_code_r;
    assign rdata     = rdata_r;
    assign dm_addr   = dm_addr_r;
    assign dm_be     = dm_be_r;
    assign dm_din    = dm_din_r;
    assign dm_wr     = dm_wr_r;
    assign dm_signed = dm_signed_r;

endmodule
